// File: rtl/spec_readout_pkg.sv
// ============================================================================
// Module   : spec_readout_pkg
// Brief    : Shared widths, header constant and FSM state type for the readout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spec_readout_pkg;

  localparam int          DATA_W     = 32;
  localparam int          BIN_LOG2   = 10;
  localparam int          RANGE_LOG2 = 4;
  localparam int          ADDR_W     = BIN_LOG2 + RANGE_LOG2;
  localparam logic [15:0] HDR_MAGIC  = 16'hA55A;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    STRM  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spec_readout_streamer_skid_fifo.sv
// ============================================================================
// Module   : spec_skid_fifo
// Brief    : 2-entry FIFO with registered head (no fall-through) and occupancy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spec_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  // Caller never pushes when full nor pops when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/spec_readout_streamer.sv
// ============================================================================
// Module   : spec_readout_streamer
// Brief    : Streams a header word then every DPRAM port-B word as a framed stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spec_readout_streamer
  import spec_readout_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       pulse_count_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rd_own_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_sof_o,
  output logic              out_eof_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_pcount;
  logic [ADDR_W-1:0] r_addr;
  logic              r_infl;
  logic              r_infl_eof;
  logic              r_done;
  logic              r_overrun;

  logic [DATA_W:0]   w_head;
  logic [1:0]        w_fifo_cnt;
  logic [1:0]        w_occ;
  logic              w_pop;
  logic              w_eof_acc;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              w_sof;
  logic              w_eof;

  // Each entry carries the eof tag in its MSB.
  spec_skid_fifo #(.WIDTH(DATA_W + 1)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (r_infl),
    .i_push_data ({r_infl_eof, rd_data_i}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_fifo_cnt)
  );

  assign w_pop     = ((r_state == STRM) || (r_state == DRAIN)) && (w_fifo_cnt != 2'd0) && out_ready_i;
  assign w_eof_acc = w_pop && w_head[DATA_W];
  // Occupancy after this cycle's pop, so a steady stream issues every clock.
  assign w_occ     = w_fifo_cnt - {1'b0, w_pop};
  assign w_last_issue = w_issue && (r_addr == ADDR_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_data      = '0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = HDR;
      end
      HDR: begin
        w_valid = 1'b1;
        w_data  = {HDR_MAGIC, r_pcount};
        w_sof   = 1'b1;
        w_issue = out_ready_i;
        if (out_ready_i) w_state_nxt = STRM;
      end
      STRM, DRAIN: begin
        w_valid = (w_fifo_cnt != 2'd0);
        if (w_valid) begin
          w_data = w_head[DATA_W-1:0];
          w_eof  = w_head[DATA_W];
        end
        if (r_state == STRM) begin
          w_issue = ((w_occ + {1'b0, r_infl}) < 2'd2);
          if (w_issue && (r_addr == ADDR_MAX)) w_state_nxt = DRAIN;
        end else if (w_eof_acc) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pcount   <= 16'd0;
      r_addr     <= '0;
      r_infl     <= 1'b0;
      r_infl_eof <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && start_i) begin
        r_pcount <= pulse_count_i;
        r_addr   <= '0;
      end else if (w_issue && (r_addr != ADDR_MAX)) begin
        r_addr <= r_addr + 1'b1;
      end
      r_infl     <= w_issue;
      r_infl_eof <= w_last_issue;
      r_done     <= w_eof_acc;
      if ((r_state != IDLE) && start_i) r_overrun <= 1'b1;
    end
  end

  assign rd_addr_o   = r_addr;
  assign rd_own_o    = (r_state != IDLE);
  assign busy_o      = (r_state != IDLE);
  assign out_valid_o = w_valid;
  assign out_data_o  = w_data;
  assign out_sof_o   = w_sof;
  assign out_eof_o   = w_eof;
  assign done_o      = r_done;
  assign overrun_o   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spec_readout_streamer.sv
// ============================================================================
// Module   : tb_spec_readout_streamer
// Brief    : Directed self-checking bench for the spectrum readout streamer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spec_readout_streamer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] pulse_count_i = 16'd0;
  logic [13:0] rd_addr_o;
  logic [31:0] rd_data_i;
  logic        rd_own_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        out_sof_o;
  logic        out_eof_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] q_data[$];
  bit          q_sof[$];
  bit          q_eof[$];
  int g_stable_err, g_max_out, g_addr_moved, g_stall_cycles;
  int g_done_cnt, g_done_gap, g_hdr_lat, g_data_lat, g_timeout, g_rst_zero_err;

  always #5 clk_i = ~clk_i;

  // DPRAM port-B model: one clock read latency.
  always @(posedge clk_i) rd_data_i <= {18'd0, rd_addr_o} ^ 32'h5A5A0000;

  spec_readout_streamer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pulse_count_i(pulse_count_i),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .rd_own_o(rd_own_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_sof_o(out_sof_o), .out_eof_o(out_eof_o), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o)
  );

  function automatic int seq_errors(input logic [15:0] pc, input int exp_n);
    int errs = 0;
    if (q_data.size() != exp_n) errs++;
    for (int i = 0; i < q_data.size(); i++) begin
      logic [31:0] e;
      e = (i == 0) ? {16'hA55A, pc} : (32'(i - 1) ^ 32'h5A5A0000);
      if (q_data[i] !== e || q_sof[i] !== (i == 0) || q_eof[i] !== (i == 16384)) errs++;
    end
    return errs;
  endfunction

  // mode 0: ready high, 1: random 50%, 2: ready high with 100-clk stall at word 3000
  task automatic run_frame(input int mode, input bit pulse, input logic [15:0] pc,
                           input int inj_word, input int abort_word,
                           input bit chain, input logic [15:0] next_pc);
    int cyc = 0, eof_cyc = -1, hdr_acc_cyc = -1, stall_left = 0;
    bit prev_stall = 0, prev_sof = 0, prev_eof = 0, injected = 0;
    bit done_flag = 0, stall_done = 0, aborted = 0;
    logic [31:0] prev_d = '0;
    logic [13:0] stall_addr = '0;
    q_data.delete(); q_sof.delete(); q_eof.delete();
    g_stable_err = 0; g_max_out = 0; g_addr_moved = 0; g_stall_cycles = 0;
    g_done_cnt = 0; g_done_gap = -1; g_hdr_lat = -1; g_data_lat = -1;
    g_timeout = 0; g_rst_zero_err = 0;
    if (pulse) begin
      @(negedge clk_i);
      start_i = 1'b1; pulse_count_i = pc; out_ready_i = 1'b1;
    end
    while (!done_flag && cyc < 40000) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      if (done_o) begin
        g_done_cnt++; g_done_gap = cyc - eof_cyc; done_flag = 1;
        if (chain) begin start_i = 1'b1; pulse_count_i = next_pc; end
      end
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (!stall_done && stall_left == 0 && q_data.size() == 3000) stall_left = 100;
          out_ready_i = (stall_left == 0);
        end
      endcase
      if (inj_word >= 0 && !injected && q_data.size() == inj_word) begin
        start_i = 1'b1; pulse_count_i = 16'hFFFF; injected = 1;
      end
      if (abort_word >= 0 && q_data.size() == abort_word) begin
        rst_i = 1'b1;
        #1;
        if (out_valid_o !== 1'b0 || out_data_o !== 32'd0 || out_sof_o !== 1'b0 ||
            out_eof_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            rd_own_o !== 1'b0 || rd_addr_o !== 14'd0 || overrun_o !== 1'b0)
          g_rst_zero_err++;
        @(negedge clk_i);
        rst_i = 1'b0;
        aborted = 1;
        break;
      end
      #1;
      if (prev_stall && (out_valid_o !== 1'b1 || out_data_o !== prev_d ||
                         out_sof_o !== prev_sof || out_eof_o !== prev_eof))
        g_stable_err++;
      if (mode == 2 && stall_left > 0) begin
        if (stall_left == 100) stall_addr = rd_addr_o;
        else if (rd_addr_o !== stall_addr) g_addr_moved++;
        stall_left--; g_stall_cycles++;
        if (stall_left == 0) stall_done = 1;
      end
      if (hdr_acc_cyc >= 0 && rd_addr_o != 14'h3FFF) begin
        int o;
        o = int'(rd_addr_o) - (q_data.size() - 1);
        if (o > g_max_out) g_max_out = o;
      end
      if (out_valid_o && g_hdr_lat < 0) g_hdr_lat = cyc;
      if (out_valid_o && q_data.size() == 1 && g_data_lat < 0) g_data_lat = cyc - hdr_acc_cyc;
      if (out_valid_o && out_ready_i) begin
        if (q_data.size() == 0) hdr_acc_cyc = cyc;
        q_data.push_back(out_data_o); q_sof.push_back(out_sof_o); q_eof.push_back(out_eof_o);
        if (out_eof_o) eof_cyc = cyc;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_d = out_data_o; prev_sof = out_sof_o; prev_eof = out_eof_o;
    end
    if (!done_flag && !aborted) g_timeout = 1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; out_ready_i = 1'b0; pulse_count_i = 16'd0;
    repeat (3) @(negedge clk_i);
    #1;
    n_total++; if (out_valid_o !== 1'b0 || out_sof_o !== 1'b0 || out_eof_o !== 1'b0)
      $display("FAIL reset_stream valid/sof/eof got %b%b%b want 000", out_valid_o, out_sof_o, out_eof_o); else n_pass++;
    n_total++; if (out_data_o !== 32'd0) $display("FAIL reset_data got %h want 0", out_data_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0 || rd_own_o !== 1'b0 || done_o !== 1'b0 || overrun_o !== 1'b0)
      $display("FAIL reset_status busy/own/done/ovr got %b%b%b%b want 0000", busy_o, rd_own_o, done_o, overrun_o); else n_pass++;
    n_total++; if (rd_addr_o !== 14'd0) $display("FAIL reset_addr got %h want 0", rd_addr_o); else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_full_frame();
    logic [31:0] first, second, last;
    run_frame(0, 1'b1, 16'd1000, -1, -1, 1'b0, 16'd0);
    first  = (q_data.size() > 0) ? q_data[0] : 32'hx;
    second = (q_data.size() > 1) ? q_data[1] : 32'hx;
    last   = (q_data.size() > 0) ? q_data[q_data.size() - 1] : 32'hx;
    n_total++; if (g_timeout !== 0) $display("FAIL full_timeout got %0d want 0", g_timeout); else n_pass++;
    n_total++; if (q_data.size() !== 16385) $display("FAIL full_len got %0d want 16385", q_data.size()); else n_pass++;
    n_total++; if (first !== 32'hA55A03E8) $display("FAIL full_header got %h want a55a03e8", first); else n_pass++;
    n_total++; if (second !== 32'h5A5A0000) $display("FAIL full_word0 got %h want 5a5a0000", second); else n_pass++;
    n_total++; if (last !== 32'h5A5A3FFF) $display("FAIL full_last got %h want 5a5a3fff", last); else n_pass++;
    n_total++; if (seq_errors(16'd1000, 16385) !== 0)
      $display("FAIL full_sequence errors got %0d want 0", seq_errors(16'd1000, 16385)); else n_pass++;
    n_total++; if (g_hdr_lat !== 1) $display("FAIL full_hdr_latency got %0d want 1", g_hdr_lat); else n_pass++;
    n_total++; if (g_data_lat !== 2) $display("FAIL full_data_latency got %0d want 2", g_data_lat); else n_pass++;
    n_total++; if (g_done_gap !== 1) $display("FAIL full_done_gap got %0d want 1", g_done_gap); else n_pass++;
    n_total++; if (busy_o !== 1'b0 || rd_own_o !== 1'b0)
      $display("FAIL full_busy_at_done busy/own got %b%b want 00", busy_o, rd_own_o); else n_pass++;
    @(negedge clk_i);
    #1;
    n_total++; if (done_o !== 1'b0) $display("FAIL full_done_pulse got %b want 0", done_o); else n_pass++;
    n_total++; if (overrun_o !== 1'b0) $display("FAIL full_overrun got %b want 0", overrun_o); else n_pass++;
  endtask

  task automatic test_stall_overrun();
    run_frame(2, 1'b1, 16'h0123, 200, -1, 1'b0, 16'd0);
    n_total++; if (g_timeout !== 0) $display("FAIL stall_timeout got %0d want 0", g_timeout); else n_pass++;
    n_total++; if (seq_errors(16'h0123, 16385) !== 0)
      $display("FAIL stall_sequence errors got %0d want 0", seq_errors(16'h0123, 16385)); else n_pass++;
    n_total++; if (g_stall_cycles !== 100) $display("FAIL stall_cycles got %0d want 100", g_stall_cycles); else n_pass++;
    n_total++; if (g_addr_moved !== 0) $display("FAIL stall_addr_frozen moves got %0d want 0", g_addr_moved); else n_pass++;
    n_total++; if (g_max_out < 1 || g_max_out > 2)
      $display("FAIL stall_outstanding got %0d want 1..2", g_max_out); else n_pass++;
    n_total++; if (g_stable_err !== 0) $display("FAIL stall_stable errors got %0d want 0", g_stable_err); else n_pass++;
    n_total++; if (overrun_o !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun_o); else n_pass++;
    repeat (3) @(negedge clk_i);
    #1;
    n_total++; if (overrun_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL overrun_sticky ovr/busy got %b%b want 10", overrun_o, busy_o); else n_pass++;
  endtask

  task automatic test_random_abort();
    run_frame(1, 1'b1, 16'hBEEF, -1, 5000, 1'b0, 16'd0);
    n_total++; if (seq_errors(16'hBEEF, 5000) !== 0)
      $display("FAIL random_sequence errors got %0d want 0", seq_errors(16'hBEEF, 5000)); else n_pass++;
    n_total++; if (g_stable_err !== 0) $display("FAIL random_stable errors got %0d want 0", g_stable_err); else n_pass++;
    n_total++; if (g_rst_zero_err !== 0) $display("FAIL abort_outputs_zero errors got %0d want 0", g_rst_zero_err); else n_pass++;
    #1;
    n_total++; if (overrun_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL abort_cleared ovr/busy got %b%b want 00", overrun_o, busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame(0, 1'b1, 16'd1, -1, -1, 1'b1, 16'd2);
    n_total++; if (seq_errors(16'd1, 16385) !== 0 || g_done_cnt !== 1)
      $display("FAIL b2b_first errors got %0d done %0d want 0 1", seq_errors(16'd1, 16385), g_done_cnt); else n_pass++;
    run_frame(0, 1'b0, 16'd2, -1, -1, 1'b0, 16'd0);
    n_total++; if (g_timeout !== 0) $display("FAIL b2b_timeout got %0d want 0", g_timeout); else n_pass++;
    n_total++; if (g_hdr_lat !== 1) $display("FAIL b2b_hdr_latency got %0d want 1", g_hdr_lat); else n_pass++;
    n_total++; if (seq_errors(16'd2, 16385) !== 0)
      $display("FAIL b2b_second errors got %0d want 0", seq_errors(16'd2, 16385)); else n_pass++;
    n_total++; if (overrun_o !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall_overrun();
    test_random_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
